// File: rtl/result_to_ascii.sv
// -----------------------------------------------------------------------------
// result_to_ascii
//   Converts a signed two's-complement value into a left-justified ASCII
//   decimal string. The first character is placed in the top byte of text, and
//   unused bytes read as 8'h00. The conversion runs sequentially: WIDTH cycles of
//   double-dabble (shift-add-3) binary-to-BCD, then one BCD digit per cycle is
//   packed into the string, then a single-cycle done pulse is issued. Latency is
//   fixed at WIDTH+DIGITS+1 edges from the accepting edge, for every value.
//
// Ports
//   clk    in   1        clock, all logic on posedge
//   rst_n  in   1        synchronous reset, active low
//   start  in   1        request conversion; accepted only when busy==0
//   value  in   WIDTH    signed operand, sampled on the accepting edge only
//   busy   out  1        conversion in progress
//   done   out  1        one-cycle pulse: text/len valid
//   text   out  8*CHARS  ASCII string, char0 at text[8*CHARS-1 -: 8]
//   len    out  LW       number of valid characters (1..CHARS)
// -----------------------------------------------------------------------------
module result_to_ascii #(
  parameter  int WIDTH  = 32,
  parameter  int DIGITS = 10,
  localparam int CHARS  = DIGITS + 1,
  localparam int LW     = $clog2(CHARS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     value,
  output logic                 busy,
  output logic                 done,
  output logic [8*CHARS-1:0]   text,
  output logic [LW-1:0]        len
);

  localparam int CNT_MAX = (WIDTH > DIGITS) ? WIDTH : DIGITS;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, CONV, PACK, FIN} state_t;

  state_t                state, state_d;
  logic                  neg, neg_d;
  logic [WIDTH-1:0]      mag, mag_d;
  logic [4*DIGITS-1:0]   bcd, bcd_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  started, started_d;
  logic [8*CHARS-1:0]    text_d;
  logic [LW-1:0]         len_d;
  logic                  busy_d, done_d;

  // Scratch values used only inside the combinational process.
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [3:0]            nib;
  int                    pos;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    neg_d     = neg;
    mag_d     = mag;
    bcd_d     = bcd;
    cnt_d     = cnt;
    started_d = started;
    text_d    = text;
    len_d     = len;
    busy_d    = busy;
    done_d    = 1'b0;
    bcd_adj   = bcd;
    nib       = '0;
    pos       = 0;

    case (state)
      IDLE: begin
        if (start) begin
          neg_d     = value[WIDTH-1];
          // Negating the most negative value wraps to 2**(WIDTH-1), which is
          // exactly its magnitude when read as unsigned.
          mag_d     = value[WIDTH-1] ? (~value + 1'b1) : value;
          bcd_d     = '0;
          cnt_d     = '0;
          started_d = 1'b0;
          text_d    = '0;
          len_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end

      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
        mag_d = {mag[WIDTH-2:0], 1'b0};
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = PACK;
        end
      end

      PACK: begin
        // The BCD register is shifted up one nibble per cycle, so the digit
        // under consideration is always the top nibble.
        nib   = bcd[4*DIGITS-1 -: 4];
        bcd_d = {bcd[4*DIGITS-5:0], 4'h0};
        if (started || (nib != 4'h0) || (cnt == CW'(DIGITS - 1))) begin
          pos = int'(len);
          if (!started && neg) begin
            text_d[8*(CHARS-1-pos) +: 8] = 8'h2D;
            pos = pos + 1;
          end
          text_d[8*(CHARS-1-pos) +: 8] = 8'h30 + {4'h0, nib};
          len_d     = LW'(pos + 1);
          started_d = 1'b1;
        end
        cnt_d = cnt + 1'b1;
        if (cnt == CW'(DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = FIN;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values computed from the same pre-edge state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      neg     <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      started <= 1'b0;
      text    <= '0;
      len     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      neg     <= neg_d;
      mag     <= mag_d;
      bcd     <= bcd_d;
      cnt     <= cnt_d;
      started <= started_d;
      text    <= text_d;
      len     <= len_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_result_to_ascii.sv
// -----------------------------------------------------------------------------
// tb_result_to_ascii
//   Self-checking bench for result_to_ascii at default parameters. Expected
//   strings come from formatting the signed value with $sformatf("%0d") and
//   packing the characters from the top byte down.
// -----------------------------------------------------------------------------
module tb_result_to_ascii;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int CHARS  = DIGITS + 1;
  localparam int LW     = $clog2(CHARS + 1);
  localparam int LAT    = WIDTH + DIGITS + 1;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   value = '0;
  logic               busy;
  logic               done;
  logic [8*CHARS-1:0] text;
  logic [LW-1:0]      len;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_to_ascii #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .text  (text),
    .len   (len)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal text of the signed value, packed first-char-high.
  function automatic void model(input logic [WIDTH-1:0] v,
                                output logic [8*CHARS-1:0] t,
                                output logic [LW-1:0] l);
    string s;
    s = $sformatf("%0d", $signed(v));
    t = '0;
    for (int i = 0; i < s.len(); i++) t[8*(CHARS-1-i) +: 8] = s[i];
    l = LW'(s.len());
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion from the current cycle and follows it to done.
  // Returns one cycle after the accepting edge + LAT, i.e. in the done cycle.
  task automatic run_conv(input logic [WIDTH-1:0] v, input string tag);
    logic [8*CHARS-1:0] et;
    logic [LW-1:0]      el;
    int                 n;
    model(v, et, el);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = ~v;                      // changing value while busy must not matter
    check({tag, " busy_after_start"}, busy, 1'b1);
    check({tag, " text_cleared"}, text, '0);
    n = 0;
    while (!done && n < LAT + 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " text"}, text, et);
    check({tag, " len"}, len, el);
    check({tag, " busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    logic [8*CHARS-1:0] et;
    logic [LW-1:0]      el;
    logic [WIDTH-1:0]   rv;
    int                 ndone;
    int                 lat;
    logic [8*CHARS-1:0] got;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset text", text, '0);
    check("reset len",  len,  '0);
    rst_n = 1'b1;
    tick();

    // Zero, then verify the pulse is one cycle and text/len hold afterwards
    run_conv(32'd0, "zero");
    tick();
    check("zero done_pulse_width", done, 1'b0);
    model(32'd0, et, el);
    check("zero text_hold", text, et);
    check("zero len_hold", len, el);
    tick();

    run_conv(32'd12345, "pos12345");
    tick();
    run_conv(-32'sd7, "neg7");
    tick();
    run_conv(32'h8000_0000, "min");
    tick();

    // Max positive, then back-to-back start in the done cycle
    run_conv(32'h7FFF_FFFF, "max");
    check("b2b in_done_cycle", done, 1'b1);
    run_conv(32'd1, "b2b_one");
    tick();

    // Start while busy is ignored
    model(32'd999, et, el);
    start = 1'b1;
    value = 32'd999;
    tick();
    ndone = 0;
    lat   = 0;
    got   = '0;
    for (int c = 1; c <= 60; c++) begin
      start = (c == 10);
      if (c == 10) value = 32'd5;
      tick();
      if (done) begin
        ndone++;
        lat = c;
        got = text;
      end
    end
    start = 1'b0;
    check("busy_start done_count", ndone, 1);
    check("busy_start latency", lat, LAT);
    check("busy_start text", got, et);
    tick();

    // Reset during CONV aborts the conversion
    start = 1'b1;
    value = -32'sd42;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    check("abort_conv busy", busy, 1'b0);
    check("abort_conv text", text, '0);
    check("abort_conv len", len, '0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_conv no_done", ndone, 0);
    run_conv(32'd42, "after_abort42");
    tick();

    // Reset during PACK, when text is already partially filled
    start = 1'b1;
    value = -32'sd1234567;
    tick();
    start = 1'b0;
    repeat (40) tick();
    rst_n = 1'b0;
    tick();
    check("abort_pack text", text, '0);
    check("abort_pack len", len, '0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_pack no_done", ndone, 0);

    // Randomized values across magnitudes and signs
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       rv = WIDTH'($urandom_range(0, 99));
        1:       rv = WIDTH'($urandom_range(0, 99999));
        2:       rv = $urandom;
        default: rv = -WIDTH'($urandom_range(1, 1000000));
      endcase
      run_conv(rv, $sformatf("rand%0d", i));
      if ((i % 3) != 0) tick();    // mix idle gaps with back-to-back starts
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
